// File: rtl/rip_ex_issue_if.sv
// rip_ex_issue_if: decode-to-execute issue handshake and ALU operand bus
//  master: decode side (drives the decoded instruction, sees id_ready and the ALU operand strobe)
//  slave : issue controller (consumes the instruction, drives ex_ready/ex_rs1/ex_rs2)
interface rip_ex_issue_if;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we;
  logic        id_is_load;
  logic        ex_ready;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we, id_is_load,
    input  id_ready, ex_ready, ex_rs1, ex_rs2
  );
  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we, id_is_load,
    output id_ready, ex_ready, ex_rs1, ex_rs2
  );
endinterface

// File: rtl/rip_ex_issue.sv
// rip_ex_issue: execute-stage issue controller with RAW forwarding and load-use stall
//  clk, rst_n           clock, asynchronous active-low reset
//  bus (slave)          decoded instruction in (id_*), ALU operands/strobe out (ex_*)
//  rf_rs1/rs2_data      register file read data
//  alu_rslt             ALU registered result of the last issued instruction
//  wb_valid/rd/data     writeback port
//  mem_busy, flush      hold issue / discard the decode entry
//  perf_issue/stall     counters, present only with RIP_ISSUE_PERF_EN defined
module rip_ex_issue #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  rip_ex_issue_if.slave    bus,
  input  logic [31:0]      rf_rs1_data,
  input  logic [31:0]      rf_rs2_data,
  input  logic [31:0]      alu_rslt,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd_addr,
  input  logic [31:0]      wb_data,
  input  logic             mem_busy,
  input  logic             flush,
  output logic [CNT_W-1:0] perf_issue,
  output logic [CNT_W-1:0] perf_stall
);
  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;
  logic       state;
  logic       ex_vld, ex_we, ex_ld;
  logic [4:0] ex_rd, ld_rd;
  logic       wb_ld, dep, stall, issue;
  // A load in the ALU slot has no result in alu_rslt; its data arrives via writeback.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    return (a == 5'd0) ? 32'd0 :
           (ex_vld && ex_we && !ex_ld && ex_rd == a) ? alu_rslt :
           (wb_valid && wb_rd_addr == a) ? wb_data : rf;
  endfunction
  always_comb begin
    wb_ld        = wb_valid && wb_rd_addr == ld_rd;
    dep          = (bus.id_rs1_addr != 5'd0 && bus.id_rs1_addr == ld_rd) ||
                   (bus.id_rs2_addr != 5'd0 && bus.id_rs2_addr == ld_rd);
    // Only one load may be outstanding, so a second load waits even if the first returns now.
    stall        = (state == LOAD_WAIT) && ((dep && !wb_ld) || bus.id_is_load);
    issue        = rst_n && bus.id_valid && !stall && !mem_busy && !flush;
    bus.ex_ready = issue;
    bus.id_ready = issue || (rst_n && bus.id_valid && flush);
    bus.ex_rs1   = fwd(bus.id_rs1_addr, rf_rs1_data);
    bus.ex_rs2   = fwd(bus.id_rs2_addr, rf_rs2_data);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld <= 1'b0;
      ex_rd  <= 5'd0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      state  <= RUN;
      ld_rd  <= 5'd0;
    end else begin
      if (issue) begin
        ex_vld <= 1'b1;
        ex_rd  <= bus.id_rd_addr;
        ex_we  <= bus.id_rd_we;
        ex_ld  <= bus.id_is_load;
      end
      if (issue && bus.id_is_load && bus.id_rd_we && bus.id_rd_addr != 5'd0) begin
        state <= LOAD_WAIT;
        ld_rd <= bus.id_rd_addr;
      end else if (state == LOAD_WAIT && wb_ld) begin
        state <= RUN;
      end
    end
  end
`ifdef RIP_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (issue) perf_issue <= perf_issue + 1'b1;
      if (bus.id_valid && stall && !flush) perf_stall <= perf_stall + 1'b1;
    end
  end
`else
  assign perf_issue = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_rip_ex_issue.sv
// tb_rip_ex_issue: table-driven directed check of rip_ex_issue
module tb_rip_ex_issue;
  typedef struct {
    logic [31:0] v, rs1, rs2, rd, we, ld, rf1, rf2, alu, wbv, wbrd, wbd, mb, fl;
    logic [31:0] er, ir, o1, o2, stl;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rf_rs1_data, rf_rs2_data, alu_rslt, wb_data;
  logic        wb_valid, mem_busy, flush;
  logic [4:0]  wb_rd_addr;
  logic [31:0] perf_issue, perf_stall;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_iss = 0;
  int          n_stl = 0;
  vec_t        tbl [21];
  rip_ex_issue_if bus();
  rip_ex_issue #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .alu_rslt(alu_rslt),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .mem_busy(mem_busy), .flush(flush),
    .perf_issue(perf_issue), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    bus.id_valid    = t.v[0];
    bus.id_rs1_addr = t.rs1[4:0];
    bus.id_rs2_addr = t.rs2[4:0];
    bus.id_rd_addr  = t.rd[4:0];
    bus.id_rd_we    = t.we[0];
    bus.id_is_load  = t.ld[0];
    rf_rs1_data     = t.rf1;
    rf_rs2_data     = t.rf2;
    alu_rslt        = t.alu;
    wb_valid        = t.wbv[0];
    wb_rd_addr      = t.wbrd[4:0];
    wb_data         = t.wbd;
    mem_busy        = t.mb[0];
    flush           = t.fl[0];
  endtask
  task automatic chk_perf(input string tag, input int iss, input int stl);
    int ei, es;
`ifdef RIP_ISSUE_PERF_EN
    ei = iss;
    es = stl;
`else
    ei = 0;
    es = 0;
`endif
    chk({tag, "_perf_issue"}, perf_issue, ei);
    chk({tag, "_perf_stall"}, perf_stall, es);
  endtask
  initial begin
    //        v rs1 rs2 rd we ld  rf1     rf2    alu          wbv wbrd wbd      mb fl  er ir o1       o2       stl
    tbl[0]  = '{1, 7, 0, 1, 1, 0, 'h111,  'h222, 'hAAAA,      0, 0, 0,        0, 0,  1, 1, 'h111,  0,       0};
    tbl[1]  = '{1, 8, 0, 2, 1, 0, 'h333,  'h222, 'h5,         0, 0, 0,        0, 0,  1, 1, 'h333,  0,       0};
    tbl[2]  = '{1, 1, 2, 3, 1, 0, 'h444,  'h555, 'h77,        0, 0, 0,        0, 0,  1, 1, 'h444,  'h77,    0};
    tbl[3]  = '{1, 3, 3, 4, 1, 0, 9,      9,     'h10,        0, 0, 0,        0, 0,  1, 1, 'h10,   'h10,    0};
    tbl[4]  = '{1, 4, 6, 0, 1, 0, 'h44,   'h66,  'h20,        1, 4, 'hBEEF,   0, 0,  1, 1, 'h20,   'h66,    0};
    tbl[5]  = '{1, 0, 0, 5, 0, 0, 'h50,   'h51,  'hFFFFFFFF,  1, 0, 'h1234,   0, 0,  1, 1, 0,      0,       0};
    tbl[6]  = '{1, 5, 0, 9, 1, 0, 'h55,   0,     'hCAFE,      0, 0, 0,        1, 0,  0, 0, 'h55,   0,       0};
    tbl[7]  = '{1, 5, 9, 10, 0, 0, 'h55,  'h99,  'hCAFE,      0, 0, 0,        0, 0,  1, 1, 'h55,   'h99,    0};
    tbl[8]  = '{1, 1, 0, 5, 1, 1, 'h1000, 0,     'h3,         0, 0, 0,        0, 0,  1, 1, 'h1000, 0,       0};
    tbl[9]  = '{1, 5, 0, 6, 1, 0, 'h50,   0,     'h1111,      0, 0, 0,        0, 0,  0, 0, 'h50,   0,       1};
    tbl[10] = '{1, 5, 0, 6, 1, 0, 'h50,   0,     'h1111,      0, 0, 0,        1, 0,  0, 0, 'h50,   0,       1};
    tbl[11] = '{1, 5, 0, 6, 1, 0, 'h50,   0,     'h1111,      0, 0, 0,        0, 0,  0, 0, 'h50,   0,       1};
    tbl[12] = '{1, 5, 0, 6, 1, 0, 'h50,   0,     'h1111,      1, 5, 'hDEAD,   0, 0,  1, 1, 'hDEAD,  0,       0};
    tbl[13] = '{1, 6, 0, 7, 1, 1, 'h60,   0,     'h42,        0, 0, 0,        0, 0,  1, 1, 'h42,   0,       0};
    tbl[14] = '{1, 8, 9, 11, 1, 0, 'h88,  'h99,  'h3,         0, 0, 0,        0, 0,  1, 1, 'h88,   'h99,    0};
    tbl[15] = '{1, 1, 0, 12, 1, 1, 'h10,  0,     'h3,         0, 0, 0,        0, 0,  0, 0, 'h10,   0,       1};
    tbl[16] = '{1, 7, 0, 8, 1, 0, 'h70,   0,     'h3,         0, 0, 0,        0, 1,  0, 1, 'h70,   0,       0};
    tbl[17] = '{1, 0, 7, 8, 1, 0, 0,      'h70,  'h3,         0, 0, 0,        0, 0,  0, 0, 0,      'h70,    1};
    tbl[18] = '{1, 0, 7, 8, 1, 0, 0,      'h70,  'h3,         1, 7, 'h7777,   0, 0,  1, 1, 0,      'h7777,  0};
    tbl[19] = '{1, 0, 0, 0, 1, 1, 0,      0,     'h3,         0, 0, 0,        0, 0,  1, 1, 0,      0,       0};
    tbl[20] = '{1, 0, 0, 13, 1, 1, 0,     0,     'h3,         0, 0, 0,        0, 0,  1, 1, 0,      0,       0};
    drive('{1, 1, 2, 3, 1, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    #1;
    chk("rst_ex_ready", bus.ex_ready, 0);
    chk("rst_id_ready", bus.id_ready, 0);
    chk_perf("rst", 0, 0);
    bus.id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_ex_ready", i), bus.ex_ready, tbl[i].er);
      chk($sformatf("v%0d_id_ready", i), bus.id_ready, tbl[i].ir);
      chk($sformatf("v%0d_ex_rs1", i), bus.ex_rs1, tbl[i].o1);
      chk($sformatf("v%0d_ex_rs2", i), bus.ex_rs2, tbl[i].o2);
      n_iss += int'(tbl[i].er);
      n_stl += int'(tbl[i].stl);
    end
    // load to x13 outstanding: dependent stalls, then reset lands mid-cycle
    @(negedge clk);
    drive('{1, 13, 0, 14, 1, 0, 'hABC, 0, 'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk_perf("table", n_iss, n_stl);
    chk("lw13_stall", bus.ex_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_ready", bus.ex_ready, 0);
    chk("async_rst_id_ready", bus.id_ready, 0);
    chk_perf("async_rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ex_ready", bus.ex_ready, 1);
    chk("post_rst_ex_rs1", bus.ex_rs1, 'hABC);
    // late writeback for x13 is forwarded but must not disturb the FSM
    @(negedge clk);
    drive('{1, 13, 0, 15, 1, 1, 'h13, 0, 'h3, 1, 13, 'h5555, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("late_wb_ex_ready", bus.ex_ready, 1);
    chk("late_wb_ex_rs1", bus.ex_rs1, 'h5555);
    @(negedge clk);
    drive('{1, 15, 0, 16, 1, 0, 'h15, 0, 'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("lw15_stall", bus.ex_ready, 0);
    chk_perf("post_rst", 2, 0);
    bus.id_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
